// File: rtl/perf_mon_pkg.sv
// ---------------------------------------------------------------------------
// perf_mon_pkg
// Shared definitions for the pipeline performance monitor:
//   - pm_state_e : monitor FSM encoding (IDLE/RUN/FROZEN/DONE), value-exact
//                  because software decodes state_o directly.
//   - SEL_CYCLE  : read-select index of the free-running cycle counter.
//   - CNT_W_MIN / CNT_W_MAX, NUM_EVT_MIN / NUM_EVT_MAX : legal parameter range.
// Optional feature macro used by perf_monitor: PERF_MON_SNAPSHOT_EN.
// ---------------------------------------------------------------------------
package perf_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2,
    ST_DONE   = 2'd3
  } pm_state_e;

  // Counter bank index 0 is always the cycle counter; events follow at 1..N.
  localparam int unsigned SEL_CYCLE   = 0;

  localparam int unsigned CNT_W_MIN   = 8;
  localparam int unsigned CNT_W_MAX   = 64;
  localparam int unsigned NUM_EVT_MIN = 1;
  localparam int unsigned NUM_EVT_MAX = 16;

  // True when inc would overflow; the counter must hold and flag instead.
  function automatic logic is_saturated(input logic [CNT_W_MAX-1:0] val,
                                        input int unsigned         width);
    logic all_ones;
    all_ones = 1'b1;
    for (int i = 0; i < CNT_W_MAX; i++) begin
      if (i < width) begin
        all_ones = all_ones & val[i];
      end else begin
        all_ones = all_ones;
      end
    end
    return all_ones;
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// ---------------------------------------------------------------------------
// perf_sat_counter
// One saturating performance counter with a sticky overflow flag.
// An increment attempted while the counter is all-ones leaves the value
// unchanged and sets ovf_o; ovf_o stays set until clr_i or reset.
//
// Ports:
//   clk_i   in   1      clock
//   rst_i   in   1      asynchronous reset, active-low
//   clr_i   in   1      synchronous clear (value and flag), wins over inc_i
//   inc_i   in   1      count this cycle
//   cnt_o   out  CNT_W  registered counter value
//   ovf_o   out  1      registered sticky saturation flag
// ---------------------------------------------------------------------------
module perf_sat_counter
  import perf_mon_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             sat_s;

  assign sat_s = is_saturated(CNT_W_MAX'(cnt_q), CNT_W);

  // Next-state: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (sat_s) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_monitor.sv
// ---------------------------------------------------------------------------
// perf_monitor
// Pipeline performance monitor: one cycle counter plus NUM_EVT qualified
// event counters, all saturating with sticky overflow flags, an optional
// run-length limit, and a registered read-select port.
//
// Optional feature macro: PERF_MON_SNAPSHOT_EN
//   defined   : snap_i copies every live counter into a shadow bank in one
//               edge; reads come from the shadow bank while snap_valid_o=1.
//   undefined : no shadow bank, snap_i ignored, snap_valid_o tied low.
//
// Ports:
//   clk_i         in   1          clock
//   rst_i         in   1          asynchronous reset, active-low
//   start_i       in   1          level, leaves IDLE into RUN
//   clr_i         in   1          synchronous clear of counters/flags/state
//   freeze_i      in   1          level, suspends counting while high
//   limit_i       in   CNT_W      cycle limit, 0 = unlimited
//   evt_i         in   NUM_EVT    pre-qualified event pulses
//   evt_en_i      in   NUM_EVT    per-channel count enable
//   snap_i        in   1          snapshot request pulse
//   rd_sel_i      in   SEL_W      0 = cycles, k = event k-1, >NUM_EVT reads 0
//   rd_data_o     out  CNT_W      registered selected counter
//   ovf_o         out  NUM_EVT+1  sticky saturation flags (bit 0 = cycles)
//   state_o       out  2          FSM state
//   done_o        out  1          high in DONE
//   snap_valid_o  out  1          shadow bank holds a snapshot
// ---------------------------------------------------------------------------
module perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int unsigned NUM_EVT = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned SEL_W   = $clog2(NUM_EVT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clr_i,
  input  logic               freeze_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [NUM_EVT-1:0] evt_en_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic [1:0]         state_o,
  output logic               done_o,
  output logic               snap_valid_o
);

  localparam int unsigned NUM_CNT = NUM_EVT + 1;

  pm_state_e          state_q, state_d;
  logic               count_en_s;
  logic               limit_hit_s;
  logic [CNT_W-1:0]   cyc_post_s;
  logic [NUM_CNT-1:0] inc_s;
  logic [NUM_CNT-1:0] ovf_s;
  logic [CNT_W-1:0]   cnt_s [NUM_CNT];
  logic [CNT_W-1:0]   live_sel_s;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;

  // freeze_i gates counting combinationally so the rising cycle is already
  // excluded, before the state register reaches FROZEN. clr_i suppresses
  // increments because the clear must win inside the counters anyway.
  assign count_en_s = (state_q == ST_RUN) && !freeze_i && !clr_i;

  assign inc_s = {({NUM_EVT{count_en_s}} & evt_i & evt_en_i), count_en_s};

  // Equality against the post-increment count: lowering limit_i below the
  // current count can never match, so it never ends the run.
  assign cyc_post_s  = cnt_s[SEL_CYCLE] + CNT_W'(1);
  assign limit_hit_s = count_en_s && (limit_i != '0) && (cyc_post_s == limit_i);

  // Counter bank: index 0 cycles, index k event k-1.
  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    perf_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clr_i),
      .inc_i (inc_s[k]),
      .cnt_o (cnt_s[k]),
      .ovf_o (ovf_s[k])
    );
  end

  // FSM next-state; clr_i overrides every transition.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (limit_hit_s) begin
            state_d = ST_DONE;
          end else if (freeze_i) begin
            state_d = ST_FROZEN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FROZEN: begin
          if (!freeze_i) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FROZEN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Live-counter read mux; out-of-range selects fall through to zero.
  always_comb begin
    live_sel_s = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      live_sel_s = live_sel_s | ((rd_sel_i == SEL_W'(k)) ? cnt_s[k] : '0);
    end
  end

`ifdef PERF_MON_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow_q [NUM_CNT];
  logic             snap_valid_q;
  logic [CNT_W-1:0] shadow_sel_s;

  // Shadow bank: captures the pre-edge live values; clr_i beats snap_i.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        shadow_q[k] <= '0;
      end
      snap_valid_q <= 1'b0;
    end else if (clr_i) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        shadow_q[k] <= '0;
      end
      snap_valid_q <= 1'b0;
    end else if (snap_i) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        shadow_q[k] <= cnt_s[k];
      end
      snap_valid_q <= 1'b1;
    end else begin
      snap_valid_q <= snap_valid_q;
    end
  end

  // Shadow-bank read mux, same select decode as the live mux.
  always_comb begin
    shadow_sel_s = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      shadow_sel_s = shadow_sel_s | ((rd_sel_i == SEL_W'(k)) ? shadow_q[k] : '0);
    end
  end

  // Read source: shadow bank once a snapshot is held, live bank otherwise.
  always_comb begin
    rd_data_d = live_sel_s;
    if (snap_valid_q) begin
      rd_data_d = shadow_sel_s;
    end else begin
      rd_data_d = live_sel_s;
    end
  end

  assign snap_valid_o = snap_valid_q;
`else
  logic snap_unused_s;

  assign snap_unused_s = snap_i;

  // Read source: live counters only in this build.
  always_comb begin
    rd_data_d = live_sel_s;
  end

  assign snap_valid_o = 1'b0;
`endif

  // Registered read port: reflects the counters as they were before the edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign ovf_o     = ovf_s;
  assign state_o   = state_q;
  assign done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_perf_monitor.sv
// ---------------------------------------------------------------------------
// tb_perf_monitor
// Self-checking bench for perf_monitor (NUM_EVT=4, CNT_W=8). Counter reads
// go through a scoreboard queue: the expected value is pushed when rd_sel_i
// is driven and popped when the registered read data is available.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_perf_monitor;

  localparam int unsigned NUM_EVT = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SEL_W   = 3;

  logic               clk_i;
  logic               rst_i;
  logic               start_i;
  logic               clr_i;
  logic               freeze_i;
  logic [CNT_W-1:0]   limit_i;
  logic [NUM_EVT-1:0] evt_i;
  logic [NUM_EVT-1:0] evt_en_i;
  logic               snap_i;
  logic [SEL_W-1:0]   rd_sel_i;
  logic [CNT_W-1:0]   rd_data_o;
  logic [NUM_EVT:0]   ovf_o;
  logic [1:0]         state_o;
  logic               done_o;
  logic               snap_valid_o;

  int unsigned n_tests;
  int unsigned n_fail;

  logic [63:0] exp_q [$];
  string       tag_q [$];

  perf_monitor #(
    .NUM_EVT (NUM_EVT),
    .CNT_W   (CNT_W),
    .SEL_W   (SEL_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .clr_i        (clr_i),
    .freeze_i     (freeze_i),
    .limit_i      (limit_i),
    .evt_i        (evt_i),
    .evt_en_i     (evt_en_i),
    .snap_i       (snap_i),
    .rd_sel_i     (rd_sel_i),
    .rd_data_o    (rd_data_o),
    .ovf_o        (ovf_o),
    .state_o      (state_o),
    .done_o       (done_o),
    .snap_valid_o (snap_valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
    end
  endtask

  // Scoreboard read: push expectation with the select, pop once registered.
  task automatic rd_cnt(input logic [SEL_W-1:0] sel, input logic [63:0] exp,
                        input string tag);
    rd_sel_i = sel;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk_i);
    chk(tag_q.pop_front(), 64'(rd_data_o), exp_q.pop_front());
  endtask

  task automatic do_clr();
    clr_i    = 1'b1;
    start_i  = 1'b0;
    freeze_i = 1'b0;
    evt_i    = '0;
    snap_i   = 1'b0;
    tick(1);
    clr_i    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_tests  = 0;
    n_fail   = 0;
    rst_i    = 1'b0;
    start_i  = 1'b0;
    clr_i    = 1'b0;
    freeze_i = 1'b0;
    limit_i  = '0;
    evt_i    = '0;
    evt_en_i = '0;
    snap_i   = 1'b0;
    rd_sel_i = '0;

    // Reset values
    #3;
    chk("rst_rd",    64'(rd_data_o),    64'd0);
    chk("rst_ovf",   64'(ovf_o),        64'd0);
    chk("rst_state", 64'(state_o),      64'd0);
    chk("rst_done",  64'(done_o),       64'd0);
    chk("rst_snapv", 64'(snap_valid_o), 64'd0);
    tick(2);
    rst_i = 1'b1;
    tick(1);

    // Limit run: 30 counted cycles, event 0 every cycle
    limit_i  = 8'd30;
    evt_en_i = 4'b1111;
    evt_i    = 4'b0001;
    start_i  = 1'b1;
    n = 0;
    while (!done_o && n < 100) begin
      tick(1);
      n++;
    end
    chk("done_latency", 64'(n), 64'd31);
    tick(3);
    chk("done_state", 64'(state_o), 64'd3);
    rd_cnt(3'd0, 64'd30, "lim_cyc");
    rd_cnt(3'd1, 64'd30, "lim_ev0");
    rd_cnt(3'd2, 64'd0,  "lim_ev1");
    rd_cnt(3'd5, 64'd0,  "sel_oob");
    chk("lim_ovf", 64'(ovf_o), 64'd0);

    // Event enable gating and freeze
    do_clr();
    chk("clr_state", 64'(state_o), 64'd0);
    chk("clr_done",  64'(done_o),  64'd0);
    evt_en_i = 4'b1101;
    limit_i  = '0;
    start_i  = 1'b1;
    tick(1);
    chk("run_state", 64'(state_o), 64'd1);
    for (int p = 0; p < 5; p++) begin
      if (p == 2) evt_en_i = 4'b1111;
      evt_i = 4'b0010;
      tick(1);
      evt_i = 4'b0000;
      tick(1);
    end
    freeze_i = 1'b1;
    evt_i    = 4'b1111;
    tick(1);
    chk("frz_state", 64'(state_o), 64'd2);
    rd_cnt(3'd0, 64'd10, "frz_cyc");
    rd_cnt(3'd2, 64'd3,  "ev1_gated");
    rd_cnt(3'd1, 64'd0,  "frz_ev0");
    freeze_i = 1'b0;
    tick(1);
    chk("unfrz_state", 64'(state_o), 64'd1);
    tick(3);
    freeze_i = 1'b1;
    tick(1);
    rd_cnt(3'd0, 64'd13, "resume_cyc");
    rd_cnt(3'd1, 64'd3,  "resume_ev0");
    rd_cnt(3'd2, 64'd6,  "resume_ev1");
    rd_cnt(3'd4, 64'd3,  "resume_ev3");

    // Lowering the limit below the count never ends the run
    do_clr();
    evt_en_i = 4'b1111;
    limit_i  = '0;
    start_i  = 1'b1;
    tick(1);
    tick(20);
    limit_i = 8'd5;
    tick(10);
    chk("low_lim_state", 64'(state_o), 64'd1);
    chk("low_lim_done",  64'(done_o),  64'd0);
    limit_i = 8'd31;
    tick(1);
    chk("lim_next_state", 64'(state_o), 64'd3);
    rd_cnt(3'd0, 64'd31, "lim_next_cyc");

    // Saturation, then clear with start held
    do_clr();
    limit_i = '0;
    evt_i   = 4'b0100;
    start_i = 1'b1;
    tick(1);
    tick(300);
    freeze_i = 1'b1;
    tick(1);
    rd_cnt(3'd0, 64'd255, "sat_cyc");
    rd_cnt(3'd3, 64'd255, "sat_ev2");
    chk("sat_ovf", 64'(ovf_o), 64'h09);
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    chk("sclr_state", 64'(state_o), 64'd0);
    chk("sclr_ovf",   64'(ovf_o),   64'd0);
    tick(1);
    chk("sclr_run", 64'(state_o), 64'd1);
    rd_cnt(3'd3, 64'd0, "sclr_ev2");
    rd_cnt(3'd0, 64'd0, "sclr_cyc");

    // Snapshot
    do_clr();
    limit_i = '0;
    evt_i   = '0;
    start_i = 1'b1;
    tick(1);
    tick(10);
    snap_i = 1'b1;
    tick(1);
    snap_i = 1'b0;
    tick(9);
    freeze_i = 1'b1;
    tick(1);
`ifdef PERF_MON_SNAPSHOT_EN
    chk("snap_valid", 64'(snap_valid_o), 64'd1);
    rd_cnt(3'd0, 64'd10, "snap_cyc");
`else
    chk("snap_valid", 64'(snap_valid_o), 64'd0);
    rd_cnt(3'd0, 64'd20, "live_cyc");
`endif
    snap_i = 1'b1;
    clr_i  = 1'b1;
    tick(1);
    snap_i = 1'b0;
    clr_i  = 1'b0;
    chk("snapclr_valid", 64'(snap_valid_o), 64'd0);
    chk("snapclr_state", 64'(state_o),      64'd0);

    // Asynchronous reset mid-run
    do_clr();
    evt_i    = 4'b1111;
    start_i  = 1'b1;
    rd_sel_i = 3'd0;
    tick(6);
    chk("prerst_state", 64'(state_o), 64'd1);
    chk("prerst_rd_nz", 64'(rd_data_o != '0), 64'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_state", 64'(state_o),      64'd0);
    chk("arst_rd",    64'(rd_data_o),    64'd0);
    chk("arst_ovf",   64'(ovf_o),        64'd0);
    chk("arst_done",  64'(done_o),       64'd0);
    chk("arst_snapv", 64'(snap_valid_o), 64'd0);
    start_i = 1'b0;
    evt_i   = '0;
    tick(1);
    rst_i = 1'b1;
    tick(1);
    rd_cnt(3'd1, 64'd0, "arst_ev0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
